// File: rtl/nibble_seg7_display.sv
// rtl/nibble_seg7_display.sv - 7-segment display stage for the 4-bit counter nibble
// Optional feature macro: NIBBLE_SEG7_HEX_EN (hex glyphs for codes 10..15; dash otherwise)
module nibble_seg7_display #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value_in,
  input  logic       value_valid,
  input  logic       hold_btn,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]       DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       DEB_ONE  = CNT_W'(1);
  localparam logic [BLINK_DIV_W-1:0] DIV_ONE  = BLINK_DIV_W'(1);

  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   deb_lvl_q, deb_lvl_d;
  logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   held_q, held_d;
  logic [3:0]             disp_q, disp_d;
  logic [BLINK_DIV_W-1:0] stretch_q, stretch_d;
  logic [BLINK_DIV_W-1:0] presc_q, presc_d;
  logic                   dp_q, dp_d;
  logic [6:0]             seg_q, seg_d;

  logic btn_s;
  logic capture;
  logic wrap;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] glyph;
    case (code)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
`ifdef NIBBLE_SEG7_HEX_EN
      4'd10:   glyph = 7'h77;
      4'd11:   glyph = 7'h7C;
      4'd12:   glyph = 7'h39;
      4'd13:   glyph = 7'h5E;
      4'd14:   glyph = 7'h79;
      default: glyph = 7'h71;
`else
      default: glyph = 7'h40;
`endif
    endcase
    return glyph;
  endfunction

  // Next-state logic: button debounce and hold toggle, capture, wrap stretch, blink and outputs
  always_comb begin
    sync1_d   = hold_btn;
    sync2_d   = sync1_q;
    deb_lvl_d = deb_lvl_q;
    deb_cnt_d = deb_cnt_q;
    held_d    = held_q;
    btn_s     = sync2_q;

    if (btn_s == deb_lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_lvl_d = btn_s;
      deb_cnt_d = '0;
      // only a press toggles the freeze; the release is just tracked
      if (btn_s) begin
        held_d = ~held_q;
      end
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end

    // capture is gated by the held value before this edge's toggle
    capture = value_valid && !held_q;
    wrap    = capture && (value_in == 4'h0) && (disp_q == 4'hF);
    disp_d  = capture ? value_in : disp_q;

    if (wrap) begin
      stretch_d = '1;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - DIV_ONE;
    end else begin
      stretch_d = '0;
    end

    presc_d = presc_q + DIV_ONE;

    // the flash follows the registered stretch count so it lines up with the segment update
    dp_d  = held_q ? presc_q[BLINK_DIV_W-1] : (stretch_q != '0);
    seg_d = seg7_decode(disp_q);
  end

  // State registers, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_lvl_q <= 1'b0;
      deb_cnt_q <= '0;
      held_q    <= 1'b0;
      disp_q    <= 4'h0;
      stretch_q <= '0;
      presc_q   <= '0;
      dp_q      <= 1'b0;
      seg_q     <= 7'h00;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_lvl_q <= deb_lvl_d;
      deb_cnt_q <= deb_cnt_d;
      held_q    <= held_d;
      disp_q    <= disp_d;
      stretch_q <= stretch_d;
      presc_q   <= presc_d;
      dp_q      <= dp_d;
      seg_q     <= seg_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign held    = held_q;

endmodule

// File: tb/tb_nibble_seg7_display.sv
// tb/tb_nibble_seg7_display.sv - self-checking bench for nibble_seg7_display
module tb_nibble_seg7_display;

  localparam int DEB    = 16;
  localparam int DIVW   = 8;
  localparam int PERIOD = 1 << DIVW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] value_in = 4'h0;
  logic       value_valid = 1'b0;
  logic       hold_btn = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       held;

  int n_checks = 0;
  int n_errors = 0;
  int glyph[16];

  nibble_seg7_display #(.DEBOUNCE_CYCLES(DEB), .BLINK_DIV_W(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid),
    .hold_btn(hold_btn), .seg_out(seg_out), .dp_out(dp_out), .held(held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural model: edge counter, time of last wrap, raw button history
  int m_cycle, m_disp, m_held, m_level, m_run, m_r1, m_r2, m_last_wrap;
  int x_seg, x_dp, x_btn, x_held_old;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycle = 0; m_disp = 0; m_held = 0; m_level = 0; m_run = 0;
      m_r1 = 0; m_r2 = 0; m_last_wrap = -100000;
    end else begin
      m_cycle++;
      x_held_old = m_held;
      x_seg = glyph[m_disp];
      if (x_held_old != 0)
        x_dp = (((m_cycle - 1) % PERIOD) >= PERIOD / 2) ? 1 : 0;
      else
        x_dp = ((m_cycle - m_last_wrap >= 1) && (m_cycle - m_last_wrap <= PERIOD - 1)) ? 1 : 0;
      x_btn = m_r2;
      m_r2 = m_r1;
      m_r1 = int'(hold_btn);
      if (x_btn != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = x_btn;
          m_run = 0;
          if (x_btn != 0) m_held = (m_held == 0) ? 1 : 0;
        end
      end else begin
        m_run = 0;
      end
      if (value_valid && x_held_old == 0) begin
        if (value_in == 4'h0 && m_disp == 15) m_last_wrap = m_cycle;
        m_disp = int'(value_in);
      end
      #1;
      if (rst_n) begin
        check("model_seg", int'(seg_out), x_seg);
        check("model_dp", int'(dp_out), x_dp);
        check("model_held", int'(held), m_held);
      end
    end
  end

  int exp11;
  int cnt;
  int found;

  initial begin
    glyph = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07,
              32'h7F, 32'h6F, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
`ifdef NIBBLE_SEG7_HEX_EN
    glyph[10] = 32'h77; glyph[11] = 32'h7C; glyph[12] = 32'h39;
    glyph[13] = 32'h5E; glyph[14] = 32'h79; glyph[15] = 32'h71;
    exp11 = 32'h7C;
`else
    exp11 = 32'h40;
`endif

    // reset state
    repeat (3) tick();
    check("reset_seg", int'(seg_out), 32'h00);
    check("reset_dp", int'(dp_out), 0);
    check("reset_held", int'(held), 0);
    rst_n = 1'b1;

    // first edge shows 0, then value 5 captured at edge 3
    tick();
    check("first_seg_3f", int'(seg_out), 32'h3F);
    tick();
    value_in = 4'd5; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick();
    check("seg_5", int'(seg_out), 32'h6D);

    // stream 0..15,0 then count the wrap flash
    value_valid = 1'b1;
    for (int v = 0; v < 17; v++) begin
      value_in = 4'(v % 16);
      tick();
    end
    value_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (dp_out) cnt++;
    end
    check("wrap_flash_len", cnt, 255);

    // hex/dash decode of 11
    value_in = 4'd11; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick();
    check("seg_11", int'(seg_out), exp11);

    // short glitch ignored
    hold_btn = 1'b1;
    repeat (10) tick();
    hold_btn = 1'b0;
    repeat (30) tick();
    check("glitch_no_hold", int'(held), 0);

    // clean press toggles held after 18 edges
    hold_btn = 1'b1;
    found = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (held && found == 0) found = i;
    end
    check("hold_latency", found, 18);
    hold_btn = 1'b0;

    // frozen: captures ignored, dp blinks half the period
    value_in = 4'd7; value_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (dp_out) cnt++;
    end
    check("blink_duty", cnt, PERIOD / 2);
    check("frozen_seg", int'(seg_out), exp11);
    value_valid = 1'b0;

    // second press releases the freeze
    hold_btn = 1'b1;
    repeat (30) tick();
    hold_btn = 1'b0;
    repeat (30) tick();
    check("unhold", int'(held), 0);
    value_in = 4'd3; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick();
    check("seg_3_resumed", int'(seg_out), 32'h4F);

    // hold rises on the same edge as a 15->0 wrap
    value_in = 4'd15; value_valid = 1'b1;
    tick();
    hold_btn = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      value_in = (i == 18) ? 4'd0 : 4'd15;
      tick();
    end
    check("simul_held", int'(held), 1);
    value_valid = 1'b0;
    tick();
    check("simul_seg_0", int'(seg_out), 32'h3F);
    repeat (5) tick();

    // asynchronous reset mid-stretch while frozen
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", int'(seg_out), 32'h00);
    check("async_rst_dp", int'(dp_out), 0);
    check("async_rst_held", int'(held), 0);
    hold_btn = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_seg", int'(seg_out), 32'h3F);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
